// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : div_unit
//  Purpose  : Multi-cycle radix-2 restoring divider serving DIV / DIVU in the
//             execute stage. One quotient bit is produced per RUN cycle; the
//             sign fix is applied in DONE, alongside the one-cycle ready pulse.
//  Ports    : clk        - rising-edge clock
//             rst        - asynchronous reset, active-high
//             a, b       - dividend / divisor (rs / rt in E stage)
//             signed_div - 1 = DIV (two's complement), 0 = DIVU
//             start      - request a new division (sampled in IDLE only)
//             annul      - pipeline flush, abandons the current operation
//             result     - {hi = remainder, lo = quotient}
//             ready      - one-cycle pulse, result valid
//             div_stall  - stall request to the hazard unit (combinational)
//  Options  : DIV_EARLY_EXIT_EN - when defined, divide-by-zero and |a| < |b|
//             finish in a single cycle (IDLE -> DONE).
//  Revision : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_div,
    input  logic                 start,
    input  logic                 annul,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready,
    output logic                 div_stall
);

    localparam int              c_CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_nextState;
    logic [c_CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]     r_divisor;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_quo;
    logic                 r_signQ;
    logic                 r_signR;
    logic [2*WIDTH-1:0]   r_result;

    logic                 w_aNeg;
    logic                 w_bNeg;
    logic [WIDTH-1:0]     w_absA;
    logic [WIDTH-1:0]     w_absB;
    logic                 w_bZero;
    logic                 w_accept;
    logic [WIDTH:0]       w_remShift;
    logic [WIDTH:0]       w_diff;
    logic                 w_borrow;
    logic [WIDTH-1:0]     w_fixedQuo;
    logic [WIDTH-1:0]     w_fixedRem;
    logic                 w_done;
`ifdef DIV_EARLY_EXIT_EN
    logic                 w_aLtB;
`endif

    // ------------------------------------------------------------------------
    // Operand conditioning
    // ------------------------------------------------------------------------
    assign w_aNeg   = signed_div & a[WIDTH-1];
    assign w_bNeg   = signed_div & b[WIDTH-1];
    // Magnitude of the most negative value wraps to itself, which read as an
    // unsigned WIDTH-bit number is exactly 2^(WIDTH-1): no extra bit needed.
    assign w_absA   = w_aNeg ? ({WIDTH{1'b0}} - a) : a;
    assign w_absB   = w_bNeg ? ({WIDTH{1'b0}} - b) : b;
    assign w_bZero  = (b == {WIDTH{1'b0}});
    assign w_accept = start & ~annul;
`ifdef DIV_EARLY_EXIT_EN
    assign w_aLtB   = (w_absA < w_absB);
`endif

    // ------------------------------------------------------------------------
    // One restoring step. The partial remainder is always below the divisor,
    // so the shifted value fits WIDTH+1 bits and the top bit of the
    // WIDTH+1-bit difference is a reliable borrow flag.
    // ------------------------------------------------------------------------
    assign w_remShift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff     = w_remShift - {1'b0, r_divisor};
    assign w_borrow   = w_diff[WIDTH];

    assign w_fixedQuo = r_signQ ? ({WIDTH{1'b0}} - r_quo) : r_quo;
    assign w_fixedRem = r_signR ? ({WIDTH{1'b0}} - r_rem) : r_rem;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_nextState = r_state;
        div_stall   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            c_IDLE: begin
                div_stall = w_accept;
                if (w_accept) begin
`ifdef DIV_EARLY_EXIT_EN
                    w_nextState = (w_bZero | w_aLtB) ? c_DONE : c_RUN;
`else
                    w_nextState = c_RUN;
`endif
                end
            end
            c_RUN: begin
                div_stall = ~annul;
                if (annul) begin
                    w_nextState = c_IDLE;
                end else if (r_count == c_CNT_LAST) begin
                    w_nextState = c_DONE;
                end
            end
            c_DONE: begin
                w_done      = ~annul;
                w_nextState = c_IDLE;
            end
            default: begin
                w_nextState = c_IDLE;
            end
        endcase
    end

    // The fresh value is forwarded during DONE so it is valid alongside ready;
    // r_result keeps it afterwards. An annul in DONE shows the old value.
    assign ready  = w_done;
    assign result = w_done ? {w_fixedRem, w_fixedQuo} : r_result;

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count   <= '0;
            r_divisor <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_signQ   <= 1'b0;
            r_signR   <= 1'b0;
            r_result  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_count   <= '0;
                        r_divisor <= w_absB;
                        if (w_bZero) begin
                            // Divide by zero reports raw a and all-ones with
                            // no sign fix. Iterating on a zero divisor yields
                            // exactly that, so only the signs are cleared.
`ifdef DIV_EARLY_EXIT_EN
                            r_rem <= a;
                            r_quo <= '1;
`else
                            r_rem <= '0;
                            r_quo <= a;
`endif
                            r_signQ <= 1'b0;
                            r_signR <= 1'b0;
                        end
`ifdef DIV_EARLY_EXIT_EN
                        else if (w_aLtB) begin
                            // Quotient 0, remainder |a|; the remainder sign
                            // fix restores the original a.
                            r_rem   <= w_absA;
                            r_quo   <= '0;
                            r_signQ <= 1'b0;
                            r_signR <= w_aNeg;
                        end
`endif
                        else begin
                            r_rem   <= '0;
                            r_quo   <= w_absA;
                            r_signQ <= w_aNeg ^ w_bNeg;
                            r_signR <= w_aNeg;
                        end
                    end
                end
                c_RUN: begin
                    r_rem   <= w_borrow ? w_remShift[WIDTH-1:0] : w_diff[WIDTH-1:0];
                    r_quo   <= {r_quo[WIDTH-2:0], ~w_borrow};
                    r_count <= r_count + 1'b1;
                end
                c_DONE: begin
                    if (!annul) begin
                        r_result <= {w_fixedRem, w_fixedQuo};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
